kbd_seg_ctrl: RTL
=================

KBD_SEG_CTRL -- requirements
Module: kbd_seg_ctrl

Interface
- REQ-001: The block SHALL have parameter COUNT_BCD, default 1: 1 = press count is two-digit BCD 00..99; 0 = press count is binary 00..FF.
- REQ-002: The block SHALL have parameter FILTER_REPEAT, default 1: 1 = typematic repeats of the held key are not counted; 0 = every make code is counted.
- REQ-003: The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
- REQ-004: The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-005: The block SHALL have port ps2_data, input, 8 bits: deserialized PS/2 scan-code byte.
- REQ-006: The block SHALL have port ps2_valid, input, 1 bit: ps2_data holds a byte.
- REQ-007: The block SHALL have port ps2_ready, output, 1 bit: the block can accept a byte this cycle.
- REQ-008: The block SHALL have port segs_input0_1, output, 8 bits: scan code of the current or last key, for the digit 0/1 display.
- REQ-009: The block SHALL have port segs_input4_5, output, 8 bits: key-press count, for the digit 4/5 display.
- REQ-010: The block SHALL have port segs_enable, output, 1 bit: a key is currently held; display blanking control.
- REQ-011: The block SHALL have port key_ext, output, 1 bit: the current or last key carried the E0 prefix.

Function
- REQ-012: A byte SHALL be accepted only in a cycle where ps2_valid and ps2_ready are both 1.
- REQ-013: ps2_ready SHALL be 0 in the cycle after each acceptance, and 1 otherwise outside reset, giving at most one byte per 2 cycles.
- REQ-014: Holding ps2_valid while ps2_ready is 0 SHALL NOT accept the byte a second time.
- REQ-015: The prefix FSM SHALL have four states: NORM, EXT, BRK, EXT_BRK.
- REQ-016: From NORM, an accepted byte SHALL be handled as follows:
  - E0 -> EXT
  - F0 -> BRK
  - 00 or FF -> stay NORM, byte ignored
  - any other byte -> make event with ext=0, stay NORM
- REQ-017: From EXT, an accepted byte SHALL be handled as follows:
  - F0 -> EXT_BRK
  - E0 -> stay EXT
  - 00 or FF -> NORM, byte ignored
  - any other byte -> make event with ext=1, then NORM
- REQ-018: From BRK or EXT_BRK, an accepted byte SHALL be handled as follows:
  - E0, F0, 00 or FF -> protocol error, NORM, no output change
  - any other byte -> break event with ext=0 (BRK) or ext=1 (EXT_BRK), then NORM
- REQ-019: A make event with segs_enable=0 SHALL set segs_enable=1, load segs_input0_1 and key_ext, and increment the count.
- REQ-020: A make event with segs_enable=1 and the same code and ext SHALL be a repeat: no change if FILTER_REPEAT=1; count increment only if FILTER_REPEAT=0.
- REQ-021: A make event with segs_enable=1 and a different code or ext SHALL be a rollover: load the new code and ext, increment the count, and keep segs_enable=1.
- REQ-022: A break event that matches the held code and ext SHALL clear segs_enable; segs_input0_1, key_ext and the count SHALL be retained.
- REQ-023: A non-matching break event, or any break event while segs_enable=0, SHALL be ignored.
- REQ-024: All outputs SHALL be registered and SHALL reflect an accepted byte exactly 1 cycle after acceptance.
- REQ-025: With COUNT_BCD=1, the count SHALL be a low nibble with a carry into the high nibble, each digit 0..9, wrapping 99 -> 00.
- REQ-026: With COUNT_BCD=0, the count SHALL wrap FF -> 00.
- REQ-027: Count wrap SHALL produce no flag and no other side effect.

Reset
- REQ-028: With rst_n=0 at a clock edge, the FSM SHALL go to NORM and all of the following SHALL be 0 on the next cycle: segs_input0_1=00, segs_input4_5=00, segs_enable=0, key_ext=0, ps2_ready=0.
- REQ-029: ps2_ready SHALL rise in the first cycle after rst_n returns to 1.
- REQ-030: Reset mid-sequence (after E0 or F0) SHALL discard the pending prefix; a byte presented during reset SHALL NOT be accepted.

Verification
- REQ-031: The bench SHALL cover single key: bytes 1C, F0, 1C -> segs_input0_1=1C, segs_enable 1 then 0, segs_input4_5=01, key_ext=0.
- REQ-032: The bench SHALL cover typematic repeat: bytes 1C, 1C, 1C, F0, 1C with FILTER_REPEAT=1 -> count=01; with FILTER_REPEAT=0 -> count=03.
- REQ-033: The bench SHALL cover extended key: bytes E0, 75, E0, F0, 75 -> segs_input0_1=75, key_ext=1, segs_enable 1 then 0. A plain F0, 75 while E0-75 is held -> ignored, segs_enable stays 1.
- REQ-034: The bench SHALL cover rollover and wrap: preload count 99 via 99 presses of 1C/F0/1C, then 1C, then 32 without a break -> counts read 00 then 01, segs_input0_1=32, segs_enable=1; with COUNT_BCD=0 and 255 presses -> FF then 00.
- REQ-035: The bench SHALL cover protocol errors: F0, E0 -> NORM and outputs unchanged; 00 or FF in any state -> NORM, no make and no break.
- REQ-036: The bench SHALL cover handshake and reset: ps2_valid held high for 6 cycles with 1C -> exactly 3 acceptances and ps2_ready toggling 1,0,1,0,...; rst_n=0 after E0 followed by 75 -> key_ext=0, segs_input0_1=75, not extended.

Source files
------------

// File: rtl/kbd_seg_ctrl.sv
// rtl/kbd_seg_ctrl.sv - PS/2 scan-code decoder driving key-code, press-count and blanking displays
module kbd_seg_ctrl #(
    parameter bit COUNT_BCD     = 1'b1,
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    output logic       ps2_ready,
    output logic [7:0] segs_input0_1,
    output logic [7:0] segs_input4_5,
    output logic       segs_enable,
    output logic       key_ext
);

    typedef enum logic [1:0] {
        S_NORM    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BRK = 8'hF0;

    state_t     state_q, state_d;
    logic       ready_q;
    logic [7:0] code_q;
    logic [7:0] cnt_q;
    logic       en_q;
    logic       ext_q;

    logic       accept;
    logic       junk;
    logic       make_ev;
    logic       brk_ev;
    logic       ev_ext;
    logic       match;
    logic [7:0] cnt_inc;

    assign accept = ps2_valid && ready_q;
    assign junk   = (ps2_data == 8'h00) || (ps2_data == 8'hFF);

    always_comb begin
        state_d = state_q;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        ev_ext  = 1'b0;
        if (accept) begin
            case (state_q)
                S_NORM: begin
                    if (ps2_data == B_EXT)      state_d = S_EXT;
                    else if (ps2_data == B_BRK) state_d = S_BRK;
                    else if (!junk)             make_ev = 1'b1;
                end
                S_EXT: begin
                    if (ps2_data == B_BRK)      state_d = S_EXT_BRK;
                    else if (ps2_data != B_EXT) begin
                        state_d = S_NORM;
                        make_ev = !junk;
                        ev_ext  = 1'b1;
                    end
                end
                default: begin
                    // Prefix bytes after F0 are a protocol error: drop back to NORM silently.
                    state_d = S_NORM;
                    brk_ev  = !junk && (ps2_data != B_EXT) && (ps2_data != B_BRK);
                    ev_ext  = (state_q == S_EXT_BRK);
                end
            endcase
        end
    end

    assign match = en_q && (code_q == ps2_data) && (ext_q == ev_ext);

    always_comb begin
        cnt_inc = cnt_q + 8'd1;
        if (COUNT_BCD) begin
            if (cnt_q[3:0] >= 4'd9) begin
                cnt_inc[3:0] = 4'd0;
                cnt_inc[7:4] = (cnt_q[7:4] >= 4'd9) ? 4'd0 : cnt_q[7:4] + 4'd1;
            end else begin
                cnt_inc = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_NORM;
            ready_q <= 1'b0;
            code_q  <= 8'h00;
            cnt_q   <= 8'h00;
            en_q    <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= !accept;
            if (make_ev) begin
                if (!match) begin
                    en_q   <= 1'b1;
                    code_q <= ps2_data;
                    ext_q  <= ev_ext;
                    cnt_q  <= cnt_inc;
                end else if (!FILTER_REPEAT) begin
                    cnt_q <= cnt_inc;
                end
            end
            if (brk_ev && match) begin
                en_q <= 1'b0;
            end
        end
    end

    assign ps2_ready     = ready_q;
    assign segs_input0_1 = code_q;
    assign segs_input4_5 = cnt_q;
    assign segs_enable   = en_q;
    assign key_ext       = ext_q;

endmodule
